// File: rtl/ra1sh_v2.sv
// ----------------------------------------------------------------------------
// ra1sh_v2 : single-port synchronous SRAM wrapper with byte write enables,
// selectable read-first / write-first behaviour, 1- or 2-stage read pipeline
// and an optional zero-fill sweep of the whole array after reset.
//
// All state updates on the falling edge of CLK.
//
// Parameters
//   BITS           data width (multiple of 8)
//   WORD_DEPTH     number of words (<= 2**ADDR_WIDTH)
//   ADDR_WIDTH     address width
//   RD_LAT         read latency in falling edges (1 or 2)
//   WRITE_FIRST    1: a write returns the merged word, 0: the pre-write word
//   CLEAR_ON_RESET 1: zero-fill the array after reset is released
//
// Ports
//   CLK    in   clock
//   RST    in   synchronous active-high reset
//   CEN    in   chip enable, active-low
//   WEN    in   per-byte write enable, active-low (all ones = read)
//   A      in   word address
//   D      in   write data
//   OEN    in   output enable, active-low (forces Q to zero when high)
//   Q      out  read data
//   VALID  out  one-edge pulse when Q carries a fresh access result
//   BUSY   out  high while in reset or clearing; accesses are ignored
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RESET | held in / just out of reset, array untouched
// ST_CLEAR | zero-fill sweep, one word per edge starting at address 0
// ST_READY | normal operation, accesses accepted
// ----------------------------------------------------------------------------
module ra1sh_v2 #(
    parameter int BITS           = 32,
    parameter int WORD_DEPTH     = 8192,
    parameter int ADDR_WIDTH     = 13,
    parameter int RD_LAT         = 1,
    parameter int WRITE_FIRST    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CEN,
    input  logic [BITS/8-1:0]     WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [BITS-1:0]       D,
    input  logic                  OEN,
    output logic [BITS-1:0]       Q,
    output logic                  VALID,
    output logic                  BUSY
);

    localparam int NB    = BITS / 8;
    localparam int IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;
    logic             clear_we;
    logic             mem_clr;

    logic [BITS-1:0]  mem [WORD_DEPTH];

    logic             access;
    logic             in_range;
    logic [IDX_W-1:0] a_idx;
    logic [BITS-1:0]  rd_word;
    logic [BITS-1:0]  merged;
    logic [BITS-1:0]  result;
    logic             wr_req;

    logic [BITS-1:0]  s1_data;
    logic             s1_vld;
    logic [BITS-1:0]  q_out;
    logic             vld_out;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(negedge CLK) begin
        if (RST) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                cnt_d   = '0;
                state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                clear_we = 1'b1;
                if (cnt_q == IDX_W'(WORD_DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assign BUSY    = (state_q != ST_READY);
    // Reset wins over an in-flight sweep: the word under cnt is left alone
    // on the edge that aborts the clear.
    assign mem_clr = clear_we & ~RST;

    // ------------------------------------------------------------------
    // Access decode and data path
    // ------------------------------------------------------------------
    assign access   = ~RST & ~CEN & (state_q == ST_READY);
    assign in_range = ({1'b0, A} < (ADDR_WIDTH + 1)'(WORD_DEPTH));
    assign a_idx    = A[IDX_W-1:0];
    // Out-of-range addresses still index the array here; the result mux and
    // the write enable below both discard them.
    assign rd_word  = mem[a_idx];
    assign wr_req   = access & in_range & ~(&WEN);

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (!WEN[i]) begin
                merged[8*i +: 8] = D[8*i +: 8];
            end
        end
    end

    // For a pure read merged equals rd_word, so both modes agree.
    always_comb begin
        result = '0;
        if (in_range) begin
            result = (WRITE_FIRST != 0) ? merged : rd_word;
        end
    end

    // Array is deliberately not reset; only the sweep zeroes it.
    always_ff @(negedge CLK) begin
        if (mem_clr) begin
            mem[cnt_q] <= '0;
        end else if (wr_req) begin
            mem[a_idx] <= merged;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    always_ff @(negedge CLK) begin
        if (RST) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= access;
            if (access) begin
                s1_data <= result;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [BITS-1:0] q2;
            logic            v2;

            always_ff @(negedge CLK) begin
                if (RST) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= s1_vld;
                    if (s1_vld) begin
                        q2 <= s1_data;
                    end
                end
            end

            assign q_out   = q2;
            assign vld_out = v2;
        end else begin : g_lat1
            assign q_out   = s1_data;
            assign vld_out = s1_vld;
        end
    endgenerate

    // Output gating is purely combinational; the registers keep their data.
    assign Q     = OEN ? '0 : q_out;
    assign VALID = vld_out;

endmodule

// File: tb/tb_ra1sh_v2.sv
// ----------------------------------------------------------------------------
// Bench for ra1sh_v2. Two instances share one stimulus stream:
//   dut_a : RD_LAT=1, WRITE_FIRST=1
//   dut_b : RD_LAT=2, WRITE_FIRST=0
// both with WORD_DEPTH=16, ADDR_WIDTH=5 so addresses 16..31 are out of range.
// The driver keeps a word-array model of the memory and a timeline of the
// reset / clear / ready phases; each accepted access pushes the expected
// result and the edge on which it must emerge into a per-instance queue.
// A monitor pops and compares whenever VALID is seen.
// ----------------------------------------------------------------------------
module tb_ra1sh_v2;

    localparam int WD = 16;

    logic        clk;
    logic        rst;
    logic        cen;
    logic [3:0]  wen;
    logic [4:0]  a;
    logic [31:0] d;
    logic        oen;
    logic [31:0] q_a, q_b;
    logic        valid_a, valid_b;
    logic        busy_a, busy_b;

    ra1sh_v2 #(
        .BITS(32), .WORD_DEPTH(WD), .ADDR_WIDTH(5),
        .RD_LAT(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .CLK(clk), .RST(rst), .CEN(cen), .WEN(wen), .A(a), .D(d),
        .OEN(oen), .Q(q_a), .VALID(valid_a), .BUSY(busy_a)
    );

    ra1sh_v2 #(
        .BITS(32), .WORD_DEPTH(WD), .ADDR_WIDTH(5),
        .RD_LAT(2), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .CLK(clk), .RST(rst), .CEN(cen), .WEN(wen), .A(a), .D(d),
        .OEN(oen), .Q(q_b), .VALID(valid_b), .BUSY(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_m [WD];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cur_edge    = 0;
    logic cur_rst     = 1'b1;
    logic exp_busy    = 1'b1;
    logic in_rst      = 1'b1;
    int   rel_edge    = 0;
    logic mon_en      = 1'b0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s edge=%0d actual=0x%08h expected=0x%08h", nm, cur_edge, act, exp);
        end
    endtask

    // One falling edge: drive at the rising edge, advance the model for the
    // edge that follows, return 2 time units after that edge.
    task automatic step(input logic r, input logic c, input logic [3:0] w,
                        input logic [4:0] ad, input logic [31:0] dd, input logic o);
        logic [31:0] old_w, new_w, mask;
        exp_t        ea, eb;
        @(posedge clk);
        rst = r; cen = c; wen = w; a = ad; d = dd; oen = o;
        mon_en = 1'b1;
        cur_edge++;
        cur_rst = r;
        if (r) begin
            in_rst   = 1'b1;
            exp_busy = 1'b1;
            qa.delete();
            qb.delete();
        end else if (in_rst) begin
            in_rst   = 1'b0;
            rel_edge = cur_edge;
            exp_busy = 1'b1;
        end else if (cur_edge <= rel_edge + WD) begin
            mem_m[cur_edge - rel_edge - 1] = '0;
            exp_busy = (cur_edge < rel_edge + WD);
        end else begin
            exp_busy = 1'b0;
            if (!c) begin
                if (ad >= WD) begin
                    ea.data = '0;
                    eb.data = '0;
                end else begin
                    mask  = {{8{~w[3]}}, {8{~w[2]}}, {8{~w[1]}}, {8{~w[0]}}};
                    old_w = mem_m[ad];
                    new_w = (old_w & ~mask) | (dd & mask);
                    mem_m[ad] = new_w;
                    ea.data = new_w;
                    eb.data = old_w;
                end
                ea.due = cur_edge;
                eb.due = cur_edge + 1;
                qa.push_back(ea);
                qb.push_back(eb);
            end
        end
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 4'hF, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] ad, input logic [31:0] dd, input logic [3:0] w);
        step(1'b0, 1'b0, w, ad, dd, 1'b0);
    endtask

    task automatic rd(input logic [4:0] ad, input logic o);
        step(1'b0, 1'b0, 4'hF, ad, 32'hDEAD_BEEF, o);
    endtask

    // Release reset and count edges, first released edge included, until
    // BUSY has dropped.
    task automatic release_and_count(input string nm);
        int n;
        n = 0;
        do begin
            idle();
            n++;
        end while (busy_a && n < 100);
        chk(nm, n, WD + 1);
    endtask

    // Monitor: checks both instances after every falling edge.
    initial begin
        exp_t t;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (cur_rst) begin
                    last_a = '0;
                    last_b = '0;
                end
                if (valid_a) begin
                    if (qa.size() == 0) begin
                        chk("a_spurious_valid", 32'd1, 32'd0);
                    end else begin
                        t = qa.pop_front();
                        chk("a_latency", cur_edge, t.due);
                        chk("a_q", q_a, oen ? 32'h0 : t.data);
                        last_a = t.data;
                    end
                end else begin
                    if (qa.size() > 0 && qa[0].due <= cur_edge) begin
                        chk("a_missing_valid", 32'd0, 32'd1);
                        void'(qa.pop_front());
                    end
                    chk("a_q_hold", q_a, oen ? 32'h0 : last_a);
                end
                if (valid_b) begin
                    if (qb.size() == 0) begin
                        chk("b_spurious_valid", 32'd1, 32'd0);
                    end else begin
                        t = qb.pop_front();
                        chk("b_latency", cur_edge, t.due);
                        chk("b_q", q_b, oen ? 32'h0 : t.data);
                        last_b = t.data;
                    end
                end else begin
                    if (qb.size() > 0 && qb[0].due <= cur_edge) begin
                        chk("b_missing_valid", 32'd0, 32'd1);
                        void'(qb.pop_front());
                    end
                    chk("b_q_hold", q_b, oen ? 32'h0 : last_b);
                end
                chk("a_busy", busy_a, exp_busy);
                chk("b_busy", busy_b, exp_busy);
            end
        end
    end

    initial begin
        logic        r, c, o;
        logic [3:0]  w;
        logic [4:0]  ad;
        logic [31:0] dd;

        rst = 1'b1; cen = 1'b1; wen = 4'hF; a = '0; d = '0; oen = 1'b0;
        for (int i = 0; i < WD; i++) mem_m[i] = '0;

        // Reset state, then the first sweep.
        repeat (3) step(1'b1, 1'b1, 4'hF, 5'd0, 32'h0, 1'b0);
        release_and_count("first_clear_len");

        // Preload all ones, pulse reset, sweep, read back zeros.
        for (int i = 0; i < WD; i++) wr(5'(i), 32'hFFFF_FFFF, 4'h0);
        for (int i = 0; i < WD; i++) rd(5'(i), 1'b0);
        step(1'b1, 1'b1, 4'hF, 5'd0, 32'h0, 1'b0);
        release_and_count("clear_len");
        for (int i = 0; i < WD; i++) rd(5'(i), 1'b0);

        // Byte-masked write.
        wr(5'd5, 32'h1122_3344, 4'h0);
        wr(5'd5, 32'hAABB_CCDD, 4'b1010);
        rd(5'd5, 1'b0);

        // Write-first vs read-first on the same location.
        wr(5'd7, 32'h1, 4'h0);
        wr(5'd7, 32'h2, 4'h0);
        idle();

        // Back-to-back reads with gaps around them.
        wr(5'd1, 32'hA1, 4'h0);
        wr(5'd2, 32'hA2, 4'h0);
        wr(5'd3, 32'hA3, 4'h0);
        idle();
        rd(5'd1, 1'b0);
        rd(5'd2, 1'b0);
        rd(5'd3, 1'b0);
        idle();
        idle();

        // Output gating during a read.
        rd(5'd5, 1'b1);
        step(1'b0, 1'b1, 4'hF, 5'd0, 32'h0, 1'b1);
        idle();

        // Out-of-range write and read, then confirm aliases untouched.
        wr(5'd16, 32'h5555_AAAA, 4'h0);
        rd(5'd16, 1'b0);
        rd(5'd0, 1'b0);
        rd(5'd31, 1'b0);
        rd(5'd15, 1'b0);

        // Abort the sweep at cnt=8, then a full restart.
        for (int i = 0; i < WD; i++) wr(5'(i), 32'h0F0F_0000 | 32'(i), 4'h0);
        step(1'b1, 1'b1, 4'hF, 5'd0, 32'h0, 1'b0);
        repeat (9) idle();
        step(1'b1, 1'b1, 4'hF, 5'd0, 32'h0, 1'b0);
        release_and_count("restart_clear_len");
        for (int i = 0; i < WD; i++) rd(5'(i), 1'b0);

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 249) == 0);
            c  = ($urandom_range(0, 3) == 0);
            w  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            ad = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31))
                                             : 5'($urandom_range(0, 15));
            dd = $urandom;
            o  = ($urandom_range(0, 7) == 0);
            step(r, c, w, ad, dd, o);
        end

        repeat (WD + 4) idle();
        chk("drain_a", qa.size(), 32'd0);
        chk("drain_b", qb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ra1sh_v2.md
RA1SH_V2 -- requirements
Module: ra1sh_v2

Interface
REQ-001 Parameter BITS, default 32, data width; SHALL be a multiple of 8.
REQ-002 Parameter WORD_DEPTH, default 8192, number of words; SHALL be at most 2**ADDR_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 13, address width.
REQ-004 Parameter RD_LAT, default 1, read latency in CLK falling edges; legal values are 1 and 2.
REQ-005 Parameter WRITE_FIRST, default 1: 1 = write-first, 0 = read-first on a write access.
REQ-006 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the whole array after reset.
REQ-007 CLK  input  1  clock; one clock only; all state updates on the falling edge of CLK.
REQ-008 RST  input  1  reset; synchronous, active-high, sampled on the CLK falling edge.
REQ-009 CEN  input  1  chip enable, active-low.
REQ-010 WEN  input  BITS/8  per-byte write enable, active-low; all bits high = read.
REQ-011 A  input  ADDR_WIDTH  word address.
REQ-012 D  input  BITS  write data.
REQ-013 OEN  input  1  output enable, active-low.
REQ-014 Q  output  BITS  read data.
REQ-015 VALID  output  1  one-edge pulse; Q carries fresh access data.
REQ-016 BUSY  output  1  high while in reset or clearing; accesses are ignored.

Function
REQ-017 FSM SHALL have states RESET, CLEAR, READY; RST=1 forces RESET from any state on the next edge.
REQ-018 RESET: on the first edge with RST=0, go to CLEAR if CLEAR_ON_RESET=1, else go to READY.
REQ-019 CLEAR: write 0 to mem[cnt] and increment cnt each edge; cnt starts at 0; go to READY after writing WORD_DEPTH-1.
REQ-020 RST during CLEAR SHALL abort the sweep; the following clear restarts at address 0.
REQ-021 BUSY SHALL be 1 in RESET and CLEAR, and 0 in READY.
REQ-022 An access occurs on an edge in READY with CEN=0; CEN, WEN, A and D are sampled on that edge.
REQ-023 Write: for each byte i with WEN[i]=0, mem[A] byte i takes D byte i; other bytes are unchanged.
REQ-024 Write-first: the access result is the merged word (new bytes plus old unwritten bytes).
REQ-025 Read-first: the access result is the pre-write contents of mem[A].
REQ-026 Read (all WEN bits high): the access result is mem[A].
REQ-027 RD_LAT=1: the result is registered on the access edge; VALID=1 after that edge.
REQ-028 RD_LAT=2: one additional pipeline register; result and VALID appear one edge later.
REQ-029 Back-to-back accesses SHALL each produce one result, in order, with no bubbles.
REQ-030 VALID SHALL be 0 on edges where no result emerges.
REQ-031 The Q register SHALL hold its last value when no access occurs (CEN=1, or BUSY).
REQ-032 A >= WORD_DEPTH: the write is discarded; the result is all zeros; VALID behaves normally.
REQ-033 OEN=1 SHALL force Q to zero combinationally; the internal registers are unaffected.
REQ-034 The FSM SHALL ignore CEN while BUSY; no VALID is produced for ignored accesses.

Reset
REQ-035 While RST=1: Q register = 0, pipeline stage = 0, VALID = 0, BUSY = 1, cnt = 0, state = RESET.
REQ-036 The memory array is not cleared by RST itself, only by the CLEAR state.
REQ-037 With CLEAR_ON_RESET=1, BUSY SHALL fall exactly WORD_DEPTH+1 edges after the first edge with RST=0.

Verification
REQ-038 Clear: WORD_DEPTH=16 (via the parameter); preload 0xFF, pulse RST -> BUSY=1 for 17 edges after RST release; all 16 reads return 0.
REQ-039 Byte write: write 0x11223344 to addr 5, then write D=0xAABBCCDD with WEN=4'b1010 -> read returns 0x11BB33DD.
REQ-040 Modes: mem[7]=0x1; write 0x2 to addr 7 -> WRITE_FIRST=1 Q=0x2, WRITE_FIRST=0 Q=0x1; VALID=1 in both modes.
REQ-041 Latency: RD_LAT=2; read addrs 1, 2, 3 back-to-back -> VALID high for 3 consecutive edges starting 2 edges after the first access; data in order.
REQ-042 Abort and gating: assert RST mid-clear at cnt=8 -> sweep restarts at 0; OEN=1 during a read -> Q=0, VALID=1; A=WORD_DEPTH -> Q=0, memory unchanged.
